reg_scoreboard: RTL and testbench

// Read-side companion to the decode-stage register file: tracks in-flight writes to each GPR.

---
 rtl/reg_scoreboard_if.sv | 42 ++++
 rtl/reg_scoreboard.sv | 105 ++++++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_if
//  Description : Decode/writeback bundle shared by the register scoreboard and
//                the pipeline control that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5
);
    // Decode-stage request
    logic             id_valid;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_use_rt;
    logic             id_regwrite;
    logic [AW-1:0]    id_dest;
    // Writeback commit (same strobe/address as the register file write port)
    logic             wb_regwrite;
    logic [AW-1:0]    wb_rd;
    // Scoreboard responses
    logic             stall;
    logic             issue;
    logic [NREGS-1:0] busy_mask;
    logic             err_underflow;

    // Pipeline control side
    modport master (
        output id_valid, id_rs, id_rt, id_use_rt, id_regwrite, id_dest,
        output wb_regwrite, wb_rd,
        input  stall, issue, busy_mask, err_underflow
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rt, id_regwrite, id_dest,
        input  wb_regwrite, wb_rd,
        output stall, issue, busy_mask, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-GPR pending-write counters. Stalls decode while a source
//                operand has an outstanding producer or the destination
//                counter is saturated. r0 is never tracked.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    // Real counters exist only for r1..rN-1; w_cnt gives a full view with r0 at 0
    logic [CNT_W-1:0] r_cnt [1:NREGS-1];
    logic [CNT_W-1:0] w_cnt [NREGS];
    logic             r_err_underflow;

    logic w_raw_rs;
    logic w_raw_rt;
    logic w_full;
    logic w_stall;
    logic w_issue;
    logic w_inc;
    logic w_dec;
    logic w_same_reg;
    logic w_underflow;
    logic [NREGS-1:0] w_busy;

    // Flatten counters into an index-0-inclusive view, r0 reading as zero
    always_comb begin
        w_cnt[0] = c_cnt_zero;
        for (int i = 1; i < NREGS; i++) begin
            w_cnt[i] = r_cnt[i];
        end
    end

    // Hazards use only registered counts: a commit this cycle is not bypassed
    assign w_raw_rs = (w_cnt[sb.id_rs] != c_cnt_zero);
    assign w_raw_rt = sb.id_use_rt && (w_cnt[sb.id_rt] != c_cnt_zero);
    assign w_full   = sb.id_regwrite && (sb.id_dest != '0) &&
                      (w_cnt[sb.id_dest] == c_cnt_max);
    assign w_stall  = sb.id_valid && (w_raw_rs || w_raw_rt || w_full);
    assign w_issue  = sb.id_valid && !w_stall;

    assign w_inc      = w_issue && sb.id_regwrite && (sb.id_dest != '0);
    assign w_dec      = sb.wb_regwrite && (sb.wb_rd != '0);
    assign w_same_reg = (sb.id_dest == sb.wb_rd);
    // A commit against an idle counter is an error unless an issue to the same
    // register lands in the same cycle (the pair nets to no change)
    assign w_underflow = w_dec && !(w_inc && w_same_reg) &&
                         (w_cnt[sb.wb_rd] == c_cnt_zero);

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_cnt
            logic w_inc_hit;
            logic w_dec_hit;

            assign w_inc_hit = w_inc && (sb.id_dest == AW'(gi));
            assign w_dec_hit = w_dec && (sb.wb_rd == AW'(gi));

            // Per-register pending count: +1 on issue, -1 on commit, floor at 0
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= c_cnt_zero;
                end else if (w_inc_hit && !w_dec_hit) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end else if (w_dec_hit && !w_inc_hit && (r_cnt[gi] != c_cnt_zero)) begin
                    r_cnt[gi] <= r_cnt[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_err_underflow <= 1'b1;
        end
    end

    // One busy bit per register, r0 always clear
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy[i] = (w_cnt[i] != c_cnt_zero);
        end
    end

    assign sb.stall         = w_stall;
    assign sb.issue         = w_issue;
    assign sb.busy_mask     = w_busy;
    assign sb.err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard: directed scenarios
//                followed by random traffic against a pending-write model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREGS(NREGS), .AW(AW)) bus ();

    reg_scoreboard #(.NREGS(NREGS), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    // Reference model: number of outstanding writes per register
    int pend [NREGS];
    bit m_uflow;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit use_rt,
                         input bit rw, input int dest, input bit wbw, input int wbrd);
        bus.id_valid    = v;
        bus.id_rs       = AW'(rs);
        bus.id_rt       = AW'(rt);
        bus.id_use_rt   = use_rt;
        bus.id_regwrite = rw;
        bus.id_dest     = AW'(dest);
        bus.wb_regwrite = wbw;
        bus.wb_rd       = AW'(wbrd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int i = 1; i < NREGS; i++) m[i] = (pend[i] > 0);
        return m;
    endfunction

    function automatic bit model_stall();
        int rs = int'(bus.id_rs);
        int rt = int'(bus.id_rt);
        int d  = int'(bus.id_dest);
        bit hz = (pend[rs] > 0) || (bus.id_use_rt && pend[rt] > 0) ||
                 (bus.id_regwrite && d != 0 && pend[d] == MAXC);
        return bus.id_valid && hz;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) pend[i] = 0;
        m_uflow = 0;
    endtask

    // One clock: check outputs for the driven inputs, step past the edge, update the model
    task automatic cycle(input string tag);
        bit e_stall, e_issue;
        int d, r;
        #1;
        e_stall = model_stall();
        e_issue = bus.id_valid && !e_stall;
        check({tag, "_stall"}, 32'(bus.stall), 32'(e_stall));
        check({tag, "_issue"}, 32'(bus.issue), 32'(e_issue));
        check({tag, "_busy"},  bus.busy_mask,  model_mask());
        check({tag, "_uflow"}, 32'(bus.err_underflow), 32'(m_uflow));
        d = int'(bus.id_dest);
        r = int'(bus.wb_rd);
        @(posedge clk);
        if (e_issue && bus.id_regwrite && d != 0) pend[d]++;
        if (bus.wb_regwrite && r != 0) begin
            if (pend[r] > 0) pend[r]--;
            else m_uflow = 1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        #12;
        check("reset_busy",  bus.busy_mask, 32'h0);
        check("reset_uflow", 32'(bus.err_underflow), 32'h0);
        check("reset_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: issue to r5, reader of r5 stalls until the cycle after the commit
        drive(1, 0, 0, 0, 1, 5, 0, 0); cycle("t1_iss5");
        #1; check("t1_busy20", bus.busy_mask, 32'h20);
        drive(1, 5, 0, 0, 0, 0, 0, 0); cycle("t1_rd5a");
        drive(1, 5, 0, 0, 0, 0, 1, 5); cycle("t1_rd5_commit");
        drive(1, 5, 0, 0, 0, 0, 0, 0); cycle("t1_rd5_go");
        check("t1_busy0", bus.busy_mask, 32'h0);

        // 2: issue and commit to r5 in the same cycle keeps the count
        drive(1, 0, 0, 0, 1, 5, 0, 0); cycle("t2_iss5");
        drive(1, 0, 0, 0, 1, 5, 1, 5); cycle("t2_both5");
        #1; check("t2_busy5", bus.busy_mask, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 1, 5); cycle("t2_drain");

        // 3: saturate r7, fourth issue stalls, a commit frees it next cycle
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 1, 7, 0, 0); cycle("t3_fill");
        end
        drive(1, 0, 0, 0, 1, 7, 0, 0); cycle("t3_full");
        drive(1, 0, 0, 0, 1, 7, 1, 7); cycle("t3_full_commit");
        drive(1, 0, 0, 0, 1, 7, 0, 0); cycle("t3_fourth_go");
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 7); cycle("t3_drain");
        end

        // 4: r0 writes are ignored, reads of r0 never stall
        drive(1, 0, 0, 1, 1, 0, 1, 0); cycle("t4_r0");
        drive(1, 0, 0, 1, 0, 0, 0, 0); cycle("t4_r0_read");

        // 5: commit to idle r9 sets the sticky error
        drive(0, 0, 0, 0, 0, 0, 1, 9); cycle("t5_uflow");
        idle(); cycle("t5_sticky1");
        idle(); cycle("t5_sticky2");

        // 6: async reset mid-cycle clears state with no clock edge
        drive(1, 0, 0, 0, 1, 3, 0, 0); cycle("t6_iss3a");
        drive(1, 0, 0, 0, 1, 3, 0, 0); cycle("t6_iss3b");
        drive(1, 0, 0, 0, 1, 4, 0, 0); cycle("t6_iss4");
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_busy",  bus.busy_mask, 32'h0);
        check("t6_async_uflow", 32'(bus.err_underflow), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 3, 0, 0, 0, 0, 0, 0); cycle("t6_rd3");

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            int r;
            bit wbw;
            r   = int'($urandom_range(0, 7));
            wbw = (pend[r] > 0 && $urandom_range(0, 3) != 0) || ($urandom_range(0, 63) == 0);
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), wbw, r);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence ever stalls on a clock wait
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
